regfile_mp_be: RTL and testbench
================================

Name: regfile_mp_be

Overview:
- Parametrised successor to the team's 16x32 single-port register file.
- Adds configurable width, depth and number of read ports.
- Adds per-byte write enables, registered reads with a valid strobe, and write-to-read bypass.
- Adds a sequential bulk-clear engine with busy/done handshake; sits in the datapath as a general-purpose register bank.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of entries; 2..256, need not be a power of 2.
- ADDR_W, 4, address width; ADDR_W >= clog2(DEPTH).
- NUM_RD, 2, number of independent read ports; 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write entry index.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit b covers wr_data[8b+7:8b].
- wr_ready  out  1  write accepted this cycle; equals !busy.
- rd_en  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  port i address at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  port i data at [i*DATA_W +: DATA_W].
- rd_valid  out  NUM_RD  per-port one-cycle valid strobe.
- clr_req  in  1  request to clear all entries to 0.
- busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (async, active-high):
  - All entries go to 0.
  - rd_data=0, rd_valid=0, busy=0, clr_done=0, FSM=IDLE, clear index=0.
  - Reset asserted mid-clear aborts the clear immediately; no clr_done pulse is produced.
- Write:
  - At a rising edge with wr_en=1 and busy=0, each byte b with wr_be[b]=1 is updated in entry wr_addr.
  - Bytes with wr_be[b]=0 are unchanged.
  - wr_be=0 is a legal no-op.
  - wr_addr >= DEPTH: the write is dropped silently.
  - wr_en while busy=1: the write is dropped (wr_ready=0 tells the master).
- Read:
  - Latency is 1 cycle: rd_en[i]=1 at edge N gives rd_data[i] and rd_valid[i]=1 after edge N.
  - rd_valid[i] is 1 for exactly one cycle per request.
  - rd_en[i]=0: rd_valid[i]=0 and rd_data[i] holds its previous value.
  - rd_addr >= DEPTH: returns 0 with rd_valid=1.
  - Ports are fully independent; any number may read the same address in the same cycle.
- Bypass (write-first):
  - Applies when an accepted write and a read to the same address occur in the same cycle.
  - The read returns the merged value: new bytes where wr_be=1, old bytes elsewhere.
  - A read of the entry being cleared in the same cycle returns 0.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, index=0.
  - CLEAR: busy=1; entry[index] is set to 0 each cycle and index increments; at index=DEPTH-1 -> DONE.
  - CLEAR therefore lasts exactly DEPTH cycles.
  - DONE: busy=0, clr_done=1 for one cycle -> IDLE.
  - clr_req in CLEAR or DONE is ignored; it is not queued.
  - Reads during CLEAR are allowed and return current contents: cleared entries read 0, uncleared entries keep their old data.
- Simultaneous events:
  - wr_en and clr_req in the same IDLE cycle: the write is accepted (wr_ready=1), CLEAR starts next cycle, and the written entry is cleared later.
  - A write in the DONE cycle is accepted, since busy=0.
- Width rules:
  - Index counter is ADDR_W+1 bits wide so DEPTH=2^ADDR_W does not overflow.
  - No arithmetic is performed on data.

Test Plan:
- Reset, then read all 16 entries on both ports -> every rd_data=0x00000000, rd_valid=1 one cycle after each rd_en.
- Write 0xDEADBEEF to entry 3 with be=4'hF, then be=4'b0010 with data 0x0000AA00, then read port 1 at 3 -> 0xDEADAAEF.
- Same cycle: write 0x12345678 to entry 5 with be=4'b0101 (old value 0xFFFFFFFF), port 0 reads 5 -> next cycle rd_data0=0xFF34FF78.
- Fill all entries with their index, pulse clr_req -> busy=1 for exactly 16 cycles, clr_done pulses in cycle 17, then all reads return 0.
  - A write during busy -> wr_ready=0 and the entry stays 0.
  - A read of entry 15 at clear cycle 4 -> returns 0x0000000F.
- Assert reset at clear cycle 6 -> busy=0 immediately, no clr_done pulse, all entries read 0, and a new clr_req is accepted afterwards.
- DEPTH=12 build: write to address 13 -> no entry changes; read of address 13 -> 0 with rd_valid=1.

Source files
------------

// File: rtl/regfile_mp_be_if.sv
// regfile_mp_be_if: write, read and bulk-clear signals of the multi-port register file.
interface regfile_mp_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [DATA_W/8-1:0]      wr_be;
    logic                     wr_ready;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     clr_req;
    logic                     busy;
    logic                     clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        input  wr_ready, rd_data, rd_valid, busy, clr_done
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_req,
        output wr_ready, rd_data, rd_valid, busy, clr_done
    );
endinterface

// File: rtl/regfile_mp_be.sv
// regfile_mp_be: byte-enabled register bank with NUM_RD registered read ports,
// write-first bypass and a sequential bulk-clear engine.
module regfile_mp_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic           clk,
    input  logic           reset,
    regfile_mp_be_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t                   r_state, w_next;
    logic [ADDR_W:0]          r_idx;
    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] r_rd_data;
    logic [NUM_RD-1:0]        r_rd_valid;
    logic                     w_busy, w_wr_in, w_wr_acc;
    logic [ADDR_W-1:0]        w_wa, w_ra;
    logic [DATA_W-1:0]        w_merged;
    logic [DATA_W-1:0]        w_rd_next [NUM_RD];

    assign w_busy   = r_state == CLEAR;
    assign w_wr_in  = {1'b0, bus.wr_addr} < LP_DEPTH;
    assign w_wr_acc = bus.wr_en && !w_busy && w_wr_in;
    assign w_wa     = w_wr_in ? bus.wr_addr : '0;

    always_comb begin
        w_merged = r_mem[w_wa];
        for (int b = 0; b < NB; b++)
            if (bus.wr_be[b]) w_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
    end

    // Write-first: an accepted write or the entry being cleared wins over stored data
    always_comb begin
        w_ra = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
            w_rd_next[p] = ({1'b0, w_ra} >= LP_DEPTH) || (w_busy && r_idx[ADDR_W-1:0] == w_ra) ? '0 :
                           (w_wr_acc && w_wa == w_ra) ? w_merged : r_mem[w_ra];
        end
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && bus.clr_req)    ? CLEAR :
                 (r_state == CLEAR && r_idx == LP_LAST) ? DONE :
                 (r_state == DONE)                     ? IDLE : r_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_busy ? r_idx + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
            for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
        end else begin
            r_rd_valid <= bus.rd_en;
            if (w_wr_acc) r_mem[w_wa] <= w_merged;
            if (w_busy) r_mem[r_idx[ADDR_W-1:0]] <= '0;
            for (int p = 0; p < NUM_RD; p++)
                if (bus.rd_en[p]) r_rd_data[p*DATA_W +: DATA_W] <= w_rd_next[p];
        end
    end

    assign bus.wr_ready = !w_busy;
    assign bus.busy     = w_busy;
    assign bus.clr_done = r_state == DONE;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_regfile_mp_be.sv
// tb_regfile_mp_be: randomized and directed checks of regfile_mp_be against an array model;
// a second DEPTH=12 instance covers out-of-range addressing.
module tb_regfile_mp_be;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [16];
    logic [31:0] mdl12 [12];

    regfile_mp_be_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus ();
    regfile_mp_be_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus12 ();

    regfile_mp_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NUM_RD(2)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    regfile_mp_be #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .NUM_RD(2)) dut12 (
        .clk(clk), .reset(reset), .bus(bus12));

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? d[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rdp(input int p);
        return bus.rd_data[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rdp12(input int p);
        return bus12.rd_data[p*32 +: 32];
    endfunction

    task automatic idle;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_be = 0;
        bus.rd_en = 0; bus.rd_addr = 0; bus.clr_req = 0;
        bus12.wr_en = 0; bus12.wr_addr = 0; bus12.wr_data = 0; bus12.wr_be = 0;
        bus12.rd_en = 0; bus12.rd_addr = 0; bus12.clr_req = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        idle();
        bus.wr_en = 1; bus.wr_addr = 4'(a); bus.wr_data = d; bus.wr_be = be;
        tick();
        idle();
        mdl[a] = merge(mdl[a], d, be);
    endtask

    task automatic rd(input int a0, input int a1);
        @(negedge clk);
        idle();
        bus.rd_en = 2'b11; bus.rd_addr = {4'(a1), 4'(a0)};
        tick();
        idle();
    endtask

    task automatic test_reset;
        idle();
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        for (int i = 0; i < 12; i++) mdl12[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done: got %b expected 0", bus.clr_done); end
        checks++; if (bus.rd_valid !== 2'b00) begin errors++; $display("FAIL reset_rd_valid: got %b expected 00", bus.rd_valid); end
        checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready); end
        @(negedge clk);
        reset = 0;
        for (int a = 0; a < 16; a++) begin
            rd(a, 15 - a);
            checks++; if (bus.rd_valid !== 2'b11) begin errors++; $display("FAIL reset_read_valid[%0d]: got %b expected 11", a, bus.rd_valid); end
            checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL reset_read_data[%0d]: got %h expected 0", a, bus.rd_data); end
        end
        tick();
        checks++; if (bus.rd_valid !== 2'b00) begin errors++; $display("FAIL valid_one_cycle: got %b expected 00", bus.rd_valid); end
    endtask

    task automatic test_byte_enable;
        wr(3, 32'hDEADBEEF, 4'hF);
        wr(3, 32'h0000AA00, 4'b0010);
        wr(3, 32'h11111111, 4'h0);
        rd(0, 3);
        checks++; if (rdp(1) !== 32'hDEADAAEF) begin errors++; $display("FAIL byte_enable: got %h expected deadaaef", rdp(1)); end
        checks++; if (rdp(0) !== 32'h0) begin errors++; $display("FAIL byte_enable_port0: got %h expected 0", rdp(0)); end
    endtask

    task automatic test_bypass;
        wr(5, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        idle();
        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'h12345678; bus.wr_be = 4'b0101;
        bus.rd_en = 2'b01; bus.rd_addr = {4'd0, 4'd5};
        tick();
        idle();
        mdl[5] = merge(mdl[5], 32'h12345678, 4'b0101);
        checks++; if (rdp(0) !== 32'hFF34FF78) begin errors++; $display("FAIL bypass: got %h expected ff34ff78", rdp(0)); end
        checks++; if (bus.rd_valid !== 2'b01) begin errors++; $display("FAIL bypass_valid: got %b expected 01", bus.rd_valid); end
    endtask

    task automatic test_random;
        logic [31:0] last [2];
        bit known [2];
        logic [31:0] exp_d, wd;
        logic [3:0] wbe;
        logic [1:0] ren;
        int wa, we, ra [2];
        known[0] = 0; known[1] = 0;
        last[0] = 0; last[1] = 0;
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            we = $urandom_range(1, 0); wa = $urandom_range(15, 0); wd = $urandom;
            wbe = 4'($urandom_range(15, 0)); ren = 2'($urandom_range(3, 0));
            ra[0] = $urandom_range(15, 0); ra[1] = (it % 4 == 0) ? wa : $urandom_range(15, 0);
            bus.wr_en = 1'(we); bus.wr_addr = 4'(wa); bus.wr_data = wd; bus.wr_be = wbe;
            bus.rd_en = ren; bus.rd_addr = {4'(ra[1]), 4'(ra[0])};
            for (int p = 0; p < 2; p++)
                if (ren[p]) begin
                    exp_d = mdl[ra[p]];
                    if (we == 1 && wa == ra[p]) exp_d = merge(exp_d, wd, wbe);
                    last[p] = exp_d;
                    known[p] = 1;
                end
            if (we == 1) mdl[wa] = merge(mdl[wa], wd, wbe);
            tick();
            checks++; if (bus.rd_valid !== ren) begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", it, bus.rd_valid, ren); end
            for (int p = 0; p < 2; p++)
                if (known[p]) begin
                    checks++;
                    if (rdp(p) !== last[p]) begin errors++; $display("FAIL rand_data[%0d] port %0d: got %h expected %h", it, p, rdp(p), last[p]); end
                end
        end
        idle();
    endtask

    task automatic test_clear;
        int nbusy = 0;
        int done_at = 0;
        for (int a = 0; a < 16; a++) wr(a, 32'(a), 4'hF);
        @(negedge clk);
        idle();
        bus.clr_req = 1; bus.wr_en = 1; bus.wr_addr = 2; bus.wr_data = 32'h22222222; bus.wr_be = 4'hF;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL clr_write_same_cycle: got %b expected 1", bus.wr_ready); end
        tick();
        idle();
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            if (bus.busy === 1'b1) nbusy++;
            if (bus.clr_done === 1'b1) done_at = c;
            if (done_at == 0) begin
                @(negedge clk);
                idle();
                if (c == 4) begin bus.rd_en = 2'b11; bus.rd_addr = {4'd3, 4'd15}; end
                if (c == 5) begin
                    bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 32'hCAFEBABE; bus.wr_be = 4'hF;
                    #1;
                    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_busy: got %b expected 0", bus.wr_ready); end
                end
                tick();
                if (c == 4) begin
                    checks++; if (rdp(0) !== 32'h0000000F) begin errors++; $display("FAIL read_uncleared: got %h expected 0000000f", rdp(0)); end
                    checks++; if (rdp(1) !== 32'h0) begin errors++; $display("FAIL read_being_cleared: got %h expected 0", rdp(1)); end
                end
            end
        end
        idle();
        checks++; if (done_at != 17) begin errors++; $display("FAIL clr_done_cycle: got %0d expected 17", done_at); end
        checks++; if (nbusy != 16) begin errors++; $display("FAIL busy_cycles: got %0d expected 16", nbusy); end
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'h00000099; bus.wr_be = 4'hF;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_done: got %b expected 1", bus.wr_ready); end
        tick();
        idle();
        mdl[9] = 32'h99;
        checks++; if (bus.clr_done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", bus.clr_done, bus.busy); end
        for (int a = 0; a < 16; a++) begin
            rd(a, 15 - a);
            checks++;
            if (rdp(0) !== mdl[a] || rdp(1) !== mdl[15-a]) begin errors++; $display("FAIL post_clear[%0d]: got %h/%h expected %h/%h", a, rdp(0), rdp(1), mdl[a], mdl[15-a]); end
        end
    endtask

    task automatic test_reset_mid_clear;
        int seen = 0;
        int got = 0;
        for (int a = 0; a < 16; a++) wr(a, ~32'(a), 4'hF);
        @(negedge clk);
        bus.clr_req = 1;
        tick();
        idle();
        repeat (5) tick();
        reset = 1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.clr_done !== 1'b0) begin errors++; $display("FAIL reset_abort: got busy=%b done=%b expected 0 0", bus.busy, bus.clr_done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 16; i++) mdl[i] = 0;
        for (int i = 0; i < 12; i++) mdl12[i] = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.clr_done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL no_done_after_abort: got %0d active cycles expected 0", seen); end
        for (int a = 0; a < 16; a++) begin
            rd(a, a);
            checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL abort_read[%0d]: got %h expected 0", a, bus.rd_data); end
        end
        @(negedge clk);
        bus.clr_req = 1;
        tick();
        idle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL new_clr_accept: got %b expected 1", bus.busy); end
        for (int c = 2; c <= 40 && got == 0; c++) begin
            tick();
            if (bus.clr_done === 1'b1) got = c;
        end
        checks++; if (got != 17) begin errors++; $display("FAIL new_clr_done: got %0d expected 17", got); end
    endtask

    task automatic test_out_of_range;
        @(negedge clk);
        idle();
        bus12.wr_en = 1; bus12.wr_addr = 11; bus12.wr_data = 32'hB0B0B0B0; bus12.wr_be = 4'hF;
        tick();
        mdl12[11] = 32'hB0B0B0B0;
        @(negedge clk);
        bus12.wr_addr = 13; bus12.wr_data = 32'hFFFFFFFF;
        tick();
        @(negedge clk);
        bus12.wr_addr = 12; bus12.wr_data = 32'hEEEEEEEE;
        tick();
        idle();
        for (int a = 0; a < 12; a++) begin
            @(negedge clk);
            bus12.rd_en = 2'b01; bus12.rd_addr = {4'd0, 4'(a)};
            tick();
            idle();
            checks++; if (rdp12(0) !== mdl12[a]) begin errors++; $display("FAIL oob_entry[%0d]: got %h expected %h", a, rdp12(0), mdl12[a]); end
        end
        @(negedge clk);
        bus12.rd_en = 2'b11; bus12.rd_addr = {4'd12, 4'd13};
        tick();
        idle();
        checks++; if (bus12.rd_valid !== 2'b11) begin errors++; $display("FAIL oob_valid: got %b expected 11", bus12.rd_valid); end
        checks++; if (bus12.rd_data !== 64'h0) begin errors++; $display("FAIL oob_data: got %h expected 0", bus12.rd_data); end
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid_clear();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
